// File: rtl/morse_decoder.sv
// morse_decoder: samples a Morse key line at the unit rate, classifies marks
// as dots/dashes and decodes the letters S..Z into a 3-bit code.
// Optional build macro MORSE_DEC_ERROR_EN enables the error pulse; without it
// malformed characters are drained through the ERR state and dropped silently.
module morse_decoder #(
  parameter int unsigned TICK_COUNT = 25_000_000
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error
);

  localparam int unsigned CW = $clog2(TICK_COUNT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(TICK_COUNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(TICK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, ERR} state_t;

  state_t        state, state_nxt;
  logic          key_m, key_s, key_d;
  logic          key_rise;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    sym, sym_nxt;
  logic [2:0]    count, count_nxt;
  logic [2:0]    run, run_nxt;
  logic [1:0]    gap, gap_nxt;
  logic [3:0]    aligned;
  logic          match;
  logic [2:0]    match_code;
  logic          valid_nxt;
  logic [2:0]    letter_nxt;
`ifdef MORSE_DEC_ERROR_EN
  logic          error_nxt;
`endif

  assign key_rise = key_s & ~key_d;
  assign tick     = (tick_cnt == '0);

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
      key_d <= key_s;
    end
  end

  // Unit tick counter: parked at half a unit in IDLE so samples land mid-unit.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n)
      tick_cnt <= HALF_LOAD;
    else if (state == IDLE)
      tick_cnt <= HALF_LOAD;
    else if (tick_cnt == '0)
      tick_cnt <= FULL_LOAD;
    else
      tick_cnt <= tick_cnt - CW'(1);
  end

  // Left-align the collected symbols (first symbol in MSB) and look up the letter.
  always_comb begin
    case (count)
      3'd1:    aligned = {sym[0], 3'b000};
      3'd2:    aligned = {sym[1:0], 2'b00};
      3'd3:    aligned = {sym[2:0], 1'b0};
      default: aligned = sym;
    endcase
    match      = 1'b1;
    match_code = '0;
    case ({count, aligned})
      {3'd3, 4'b0000}: match_code = 3'd0; // S ...
      {3'd1, 4'b1000}: match_code = 3'd1; // T -
      {3'd3, 4'b0010}: match_code = 3'd2; // U ..-
      {3'd4, 4'b0001}: match_code = 3'd3; // V ...-
      {3'd3, 4'b0110}: match_code = 3'd4; // W .--
      {3'd4, 4'b1001}: match_code = 3'd5; // X -..-
      {3'd4, 4'b1011}: match_code = 3'd6; // Y -.--
      {3'd4, 4'b1100}: match_code = 3'd7; // Z --..
      default:         match      = 1'b0;
    endcase
  end

  // Next-state logic: mark/space classification on each unit tick.
  always_comb begin
    state_nxt  = state;
    sym_nxt    = sym;
    count_nxt  = count;
    run_nxt    = run;
    gap_nxt    = gap;
    valid_nxt  = 1'b0;
    letter_nxt = letter;
`ifdef MORSE_DEC_ERROR_EN
    error_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        sym_nxt   = '0;
        count_nxt = '0;
        run_nxt   = '0;
        gap_nxt   = '0;
        if (key_rise) state_nxt = MARK;
      end
      MARK: begin
        if (tick) begin
          if (key_s) begin
            if (run != 3'd7) run_nxt = run + 3'd1;
          end else if (run == 3'd0) begin
            // entry glitch that vanished before the first sample: no symbol
            state_nxt = IDLE;
          end else if (run >= 3'd4 || count == 3'd4) begin
            gap_nxt   = 2'd1;
            state_nxt = ERR;
          end else begin
            sym_nxt   = {sym[2:0], (run != 3'd1)};
            count_nxt = count + 3'd1;
            gap_nxt   = 2'd1;
            state_nxt = SPACE;
          end
        end
      end
      SPACE: begin
        if (tick) begin
          if (key_s) begin
            run_nxt   = 3'd1;
            state_nxt = MARK;
          end else if (gap == 2'd2) begin
            state_nxt = IDLE;
            if (match) begin
              valid_nxt  = 1'b1;
              letter_nxt = match_code;
            end
`ifdef MORSE_DEC_ERROR_EN
            else begin
              error_nxt = 1'b1;
            end
`endif
          end else begin
            gap_nxt = gap + 2'd1;
          end
        end
      end
      default: begin // ERR: drain until a 3-unit gap
        if (tick) begin
          if (key_s) begin
            gap_nxt = '0;
          end else if (gap == 2'd2) begin
            state_nxt = IDLE;
`ifdef MORSE_DEC_ERROR_EN
            error_nxt = 1'b1;
`endif
          end else begin
            gap_nxt = gap + 2'd1;
          end
        end
      end
    endcase
  end

  // State, symbol store and registered letter/valid outputs.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sym    <= '0;
      count  <= '0;
      run    <= '0;
      gap    <= '0;
      letter <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sym    <= sym_nxt;
      count  <= count_nxt;
      run    <= run_nxt;
      gap    <= gap_nxt;
      letter <= letter_nxt;
      valid  <= valid_nxt;
    end
  end

`ifdef MORSE_DEC_ERROR_EN
  // Registered error pulse.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) error <= 1'b0;
    else          error <= error_nxt;
  end
`else
  assign error = 1'b0;
`endif

endmodule
